// File: rtl/dodger_pkg.sv
// dodger_pkg: shared constants and types for the dodger game core.
//   - game state encoding
//   - colour constants ({R,G,B} 4 bits each)
//   - visible screen size, LFSR seed/taps, block lane geometry
//   - lane_x(): pixel column of a block lane
package dodger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam logic [11:0] COL_PLAYER  = 12'h0F0;
  localparam logic [11:0] COL_BLOCK   = 12'hF00;
  localparam logic [11:0] COL_BG_IDLE = 12'h00F;
  localparam logic [11:0] COL_BG_PLAY = 12'h000;
  localparam logic [11:0] COL_BG_OVER = 12'h800;

  localparam int SCR_W = 640;
  localparam int SCR_H = 480;

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int NUM_BLOCKS   = 4;
  localparam int LANE_PITCH   = 160;
  localparam int LANE_OFFSET  = 64;
  localparam int BLK_SPD_BASE = 2;
  localparam int BLK_SPD_MAX  = 8;

  function automatic logic [9:0] lane_x(input logic [1:0] lane);
    return 10'(LANE_OFFSET + LANE_PITCH * int'(lane));
  endfunction

endpackage

// File: rtl/dodger_lfsr.sv
// dodger_lfsr: 16-bit Galois LFSR, free-running when en is high.
//   clk, reset (async, active-high, loads SEED), en : step enable
//   q : low OUT_W bits of the LFSR state
// A non-zero seed keeps the state out of the all-zero lock-up.
module dodger_lfsr
  import dodger_pkg::*;
#(
  parameter logic [15:0] SEED  = LFSR_SEED,
  parameter int          OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [OUT_W-1:0] q
);

  logic [15:0] lfsr_q, lfsr_d;

  // Shifted-out bit folds back into the tap positions.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   lfsr_q <= SEED;
    else if (en) lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/dodger_game_core.sv
// dodger_game_core: dodger game logic and pixel renderer.
//   clk, reset           : pixel clock, async active-high reset
//   x, y, display_on     : current pixel from the timing stage
//   hsync_in, vsync_in   : syncs from the timing stage (active-low)
//   btn_left/right/start : asynchronous push buttons (active-high)
//   rgb                  : registered colour, 1 clk after x/y
//   hsync_out, vsync_out : syncs delayed 1 clk to align with rgb
//   score, game_over     : blocks dodged (saturating) / OVER flag
// Game state moves only on frame_tick (x==0, y==480), i.e. during
// vertical blanking, so the renderer never sees a half-updated frame.
module dodger_game_core
  import dodger_pkg::*;
#(
  parameter int PLAYER_W     = 32,
  parameter int PLAYER_H     = 16,
  parameter int PLAYER_Y     = 448,
  parameter int PLAYER_SPEED = 4,
  parameter int BLOCK_W      = 32,
  parameter int BLOCK_H      = 32,
  parameter int SPAWN_GAP    = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        display_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_start,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [15:0] score,
  output logic        game_over
);

  localparam logic [10:0] PW      = 11'(PLAYER_W);
  localparam logic [10:0] PH      = 11'(PLAYER_H);
  localparam logic [10:0] PY      = 11'(PLAYER_Y);
  localparam logic [10:0] PSPD    = 11'(PLAYER_SPEED);
  localparam logic [10:0] BW      = 11'(BLOCK_W);
  localparam logic [10:0] BH      = 11'(BLOCK_H);
  localparam logic [10:0] PX_MAX  = 11'(SCR_W - PLAYER_W);
  localparam logic [9:0]  PX_INIT = 10'((SCR_W - PLAYER_W) / 2);
  localparam logic [10:0] Y_LIMIT = 11'(SCR_H);
  localparam logic [13:0] SPD_MAX = 14'(BLK_SPD_MAX);
  // Wide enough to count past the last activation frame and then saturate.
  localparam int FCNT_W = $clog2((NUM_BLOCKS - 1) * SPAWN_GAP + 2);
  localparam int CNT_W  = $clog2(NUM_BLOCKS + 1);

  // ---------------- button synchronisers ----------------
  logic [1:0] left_sync_q, right_sync_q;
  logic [2:0] start_sync_q;  // [1] is synchronised, [2] its previous value
  logic       start_pulse, mv_left, mv_right;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_sync_q  <= '0;
      right_sync_q <= '0;
      start_sync_q <= '0;
    end else begin
      left_sync_q  <= {left_sync_q[0], btn_left};
      right_sync_q <= {right_sync_q[0], btn_right};
      start_sync_q <= {start_sync_q[1:0], btn_start};
    end
  end

  assign start_pulse = start_sync_q[1] & ~start_sync_q[2];
  assign mv_left     = left_sync_q[1];
  assign mv_right    = right_sync_q[1];

  // ---------------- lane randomiser ----------------
  logic [1:0] lane_rnd;

  dodger_lfsr #(.SEED(LFSR_SEED), .OUT_W(2)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .q     (lane_rnd)
  );

  // ---------------- game state ----------------
  state_e                         state_q;
  logic                           game_over_q;
  logic [15:0]                    score_q, score_d;
  logic [9:0]                     px_q, px_d;
  logic [FCNT_W-1:0]              fcnt_q;
  logic [NUM_BLOCKS-1:0]          blk_act_q, blk_act_d;
  logic [NUM_BLOCKS-1:0][9:0]     blk_x_q, blk_x_d;
  logic [NUM_BLOCKS-1:0][10:0]    blk_y_q, blk_y_d;

  logic                  frame_tick, hit_any, do_init, do_step;
  logic [NUM_BLOCKS-1:0] hit, pix, wrap;
  logic [CNT_W-1:0]      wrap_cnt;
  logic [10:0]           x11, y11, px11, spd;
  logic [13:0]           spd_raw;
  logic [16:0]           score_sum;

  assign frame_tick = (x == 10'd0) && (y == 10'(SCR_H));
  assign x11  = {1'b0, x};
  assign y11  = {1'b0, y};
  assign px11 = {1'b0, px_q};

  assign spd_raw = 14'(BLK_SPD_BASE) + {1'b0, score_q[15:3]};
  assign spd     = (spd_raw > SPD_MAX) ? 11'(BLK_SPD_MAX) : spd_raw[10:0];

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
    logic [10:0] bx, by, y_step;
    logic        spawn, relane;

    assign bx     = {1'b0, blk_x_q[i]};
    assign by     = blk_y_q[i];
    assign y_step = by + spd;

    assign hit[i] = blk_act_q[i] && (bx < px11 + PW) && (px11 < bx + BW) &&
                    (by < PY + PH) && (PY < by + BH);
    assign pix[i] = blk_act_q[i] && (x11 >= bx) && (x11 < bx + BW) &&
                    (y11 >= by) && (y11 < by + BH);

    assign spawn   = !blk_act_q[i] && (fcnt_q == FCNT_W'(i * SPAWN_GAP));
    assign wrap[i] = blk_act_q[i] && (y_step >= Y_LIMIT);
    assign relane  = spawn | wrap[i];

    assign blk_act_d[i] = blk_act_q[i] | spawn;
    assign blk_x_d[i]   = relane ? lane_x(lane_rnd) : blk_x_q[i];
    assign blk_y_d[i]   = relane ? 11'd0 : (blk_act_q[i] ? y_step : by);
  end

  assign hit_any = |hit;

  always_comb begin
    wrap_cnt = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) wrap_cnt = wrap_cnt + CNT_W'(wrap[i]);
  end

  assign score_sum = {1'b0, score_q} + 17'(wrap_cnt);
  assign score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  always_comb begin
    px_d = px_q;
    if (mv_left && !mv_right)
      px_d = (px11 < PSPD) ? 10'd0 : 10'(px11 - PSPD);
    else if (mv_right && !mv_left)
      px_d = (px11 + PSPD > PX_MAX) ? 10'(PX_MAX) : 10'(px11 + PSPD);
  end

  // Collision is judged on pre-tick positions; a hit freezes everything.
  assign do_init = start_pulse && (state_q != ST_PLAY);
  assign do_step = (state_q == ST_PLAY) && frame_tick && !hit_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_pulse) state_q <= ST_PLAY;
        ST_PLAY: if (frame_tick && hit_any) begin
          state_q     <= ST_OVER;
          game_over_q <= 1'b1;
        end
        ST_OVER: if (start_pulse) begin
          state_q     <= ST_PLAY;
          game_over_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_q      <= PX_INIT;
      score_q   <= '0;
      fcnt_q    <= '0;
      blk_act_q <= '0;
      blk_x_q   <= '0;
      blk_y_q   <= '0;
    end else if (do_init) begin
      px_q      <= PX_INIT;
      score_q   <= '0;
      fcnt_q    <= '0;
      blk_act_q <= '0;
    end else if (do_step) begin
      px_q      <= px_d;
      score_q   <= score_d;
      fcnt_q    <= (fcnt_q == '1) ? fcnt_q : fcnt_q + 1'b1;
      blk_act_q <= blk_act_d;
      blk_x_q   <= blk_x_d;
      blk_y_q   <= blk_y_d;
    end
  end

  // ---------------- renderer ----------------
  logic        player_pix;
  logic [11:0] rgb_q, bg;
  logic        hsync_q, vsync_q;

  assign player_pix = (x11 >= px11) && (x11 < px11 + PW) && (y11 >= PY) && (y11 < PY + PH);

  always_comb begin
    case (state_q)
      ST_PLAY: bg = COL_BG_PLAY;
      ST_OVER: bg = COL_BG_OVER;
      default: bg = COL_BG_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      hsync_q <= hsync_in;
      vsync_q <= vsync_in;
      if (!display_on) rgb_q <= '0;
      else if (player_pix) rgb_q <= COL_PLAYER;
      else if (|pix)       rgb_q <= COL_BLOCK;
      else                 rgb_q <= bg;
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;
  assign score     = score_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_dodger_game_core.sv
// tb_dodger_game_core: random-stimulus bench for dodger_game_core with a
// behavioural game model. Frames are compressed: a handful of probe pixels
// around the player and blocks, then one x=0,y=480 clock as the frame tick.
module tb_dodger_game_core;

  localparam int S_IDLE = 0, S_PLAY = 1, S_OVER = 2;

  logic        clk = 1'b0, reset = 1'b1;
  logic [9:0]  x = '0, y = '0;
  logic        display_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_start = 1'b0;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, game_over;
  logic [15:0] score;

  int checks = 0, fails = 0;

  dodger_game_core dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .btn_left(btn_left), .btn_right(btn_right), .btn_start(btn_start),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_state, m_px, m_score, m_fcnt;
  bit          m_act [4];
  int          m_bx [4], m_by [4];
  logic [15:0] m_lfsr;
  bit          st1, st2, st3, lf1, lf2, rt1, rt2;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int          e [4] = '{16, 14, 13, 11};
    logic [15:0] mask = '0;
    logic [15:0] one = 16'd1;
    foreach (e[k]) mask |= one << (e[k] - 1);
    return (s >> 1) ^ (s[0] ? mask : 16'h0);
  endfunction

  function automatic bit in_rect(int px, int py, int rx, int ry, int w, int h);
    return px >= rx && px < rx + w && py >= ry && py < ry + h;
  endfunction

  function automatic logic [11:0] exp_pixel(int xx, int yy, bit de);
    if (!de) return 12'h000;
    if (in_rect(xx, yy, m_px, 448, 32, 16)) return 12'h0F0;
    for (int i = 0; i < 4; i++)
      if (m_act[i] && in_rect(xx, yy, m_bx[i], m_by[i], 32, 32)) return 12'hF00;
    case (m_state)
      S_IDLE:  return 12'h00F;
      S_PLAY:  return 12'h000;
      default: return 12'h800;
    endcase
  endfunction

  task automatic model_init();
    m_score = 0; m_px = 304; m_fcnt = 0;
    for (int i = 0; i < 4; i++) m_act[i] = 0;
  endtask

  task automatic model_reset();
    model_init();
    m_state = S_IDLE; m_lfsr = 16'hACE1;
    st1 = 0; st2 = 0; st3 = 0; lf1 = 0; lf2 = 0; rt1 = 0; rt2 = 0;
  endtask

  task automatic model_edge(input int xx, input int yy);
    bit pulse, tick, hit;
    int spd, lx, n;
    pulse = st2 && !st3;
    tick  = (xx == 0 && yy == 480);
    if (m_state != S_PLAY && pulse) begin
      model_init();
      m_state = S_PLAY;
    end else if (m_state == S_PLAY && tick) begin
      hit = 0;
      for (int i = 0; i < 4; i++)
        if (m_act[i] && m_bx[i] < m_px + 32 && m_px < m_bx[i] + 32 &&
            m_by[i] < 464 && 448 < m_by[i] + 32) hit = 1;
      if (hit) m_state = S_OVER;
      else begin
        if (lf2 && !rt2)      m_px = (m_px >= 4) ? m_px - 4 : 0;
        else if (rt2 && !lf2) m_px = (m_px + 4 <= 608) ? m_px + 4 : 608;
        spd = 2 + m_score / 8;
        if (spd > 8) spd = 8;
        lx = 64 + 160 * int'(m_lfsr[1:0]);
        n = 0;
        for (int i = 0; i < 4; i++) begin
          if (!m_act[i]) begin
            if (m_fcnt == i * 30) begin m_act[i] = 1; m_bx[i] = lx; m_by[i] = 0; end
          end else begin
            m_by[i] += spd;
            if (m_by[i] >= 480) begin m_by[i] = 0; m_bx[i] = lx; n++; end
          end
        end
        m_score = (m_score + n > 65535) ? 65535 : m_score + n;
        m_fcnt++;
      end
    end
    st3 = st2; st2 = st1; st1 = btn_start;
    lf2 = lf1; lf1 = btn_left;
    rt2 = rt1; rt1 = btn_right;
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input int xx, input int yy, input bit de);
    logic [11:0] er;
    bit hs, vs;
    hs = 1'($urandom); vs = 1'($urandom);
    x = 10'(xx); y = 10'(yy); display_on = de;
    hsync_in = hs; vsync_in = vs;
    er = reset ? 12'h000 : exp_pixel(xx, yy, de);
    @(posedge clk);
    if (reset) model_reset(); else model_edge(xx, yy);
    #1;
    chk("rgb", 32'(rgb), 32'(er));
    chk("hsync", 32'(hsync_out), reset ? 32'd1 : 32'(hs));
    chk("vsync", 32'(vsync_out), reset ? 32'd1 : 32'(vs));
  endtask

  task automatic frame();
    cyc(m_px, 448, 1);
    cyc(m_px > 0 ? m_px - 1 : m_px + 32, 450, 1);
    cyc(m_px + 31, 463, 1);
    cyc(m_px + 16, 464, 1);
    for (int i = 0; i < 4; i++)
      if (m_act[i]) begin
        cyc(m_bx[i], m_by[i], 1);
        cyc(m_bx[i] + 31, m_by[i] + 32, 1);
        cyc(m_bx[i] + 32, m_by[i] + 31, 1);
      end
    cyc($urandom_range(0, 639), $urandom_range(0, 479), 1);
    cyc(m_px + 5, 452, 0);
    cyc(0, 480, 0);
    chk("score", 32'(score), 32'(m_score));
    chk("game_over", 32'(game_over), 32'(m_state == S_OVER));
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    repeat (4) cyc(100, 100, 1);
    btn_start = 1'b0;
    repeat (4) cyc(120, 300, 1);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) cyc(10, 10, 1);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    #3 reset = 1'b0;

    repeat (3) frame();                       // IDLE background
    press_start();
    chk("start_over", 32'(game_over), 32'd0);

    btn_right = 1'b1;                          // drive into the right wall
    repeat (100) frame();
    btn_left = 1'b1;                           // both held: no move
    repeat (20) frame();
    btn_left = 1'b0; btn_right = 1'b0;

    n = 0;                                     // sit still while speed ramps to its cap
    while (m_state == S_PLAY && m_score < 60 && n < 2600) begin frame(); n++; end

    btn_left = 1'b1;                           // walk into lane 0 and wait to be hit
    n = 0;
    while (m_state == S_PLAY && m_px > 64 && n < 200) begin frame(); n++; end
    btn_left = 1'b0;
    n = 0;
    while (m_state == S_PLAY && n < 600) begin frame(); n++; end
    chk("over_reached", 32'(game_over), 32'd1);
    repeat (10) frame();                       // frozen OVER scene

    press_start();
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_over", 32'(game_over), 32'd0);
    repeat (100) frame();                      // staggered activations

    repeat (300) begin
      btn_left  = 1'($urandom);
      btn_right = 1'($urandom);
      frame();
      if (m_state == S_OVER) begin
        btn_left = 1'b0; btn_right = 1'b0;
        press_start();
      end
    end
    btn_left = 1'b0; btn_right = 1'b0;

    cyc(200, 200, 1);                          // asynchronous reset mid-frame
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_rgb", 32'(rgb), 32'd0);
    chk("mid_rst_hs", 32'(hsync_out), 32'd1);
    chk("mid_rst_vs", 32'(vsync_out), 32'd1);
    chk("mid_rst_score", 32'(score), 32'd0);
    chk("mid_rst_over", 32'(game_over), 32'd0);
    model_reset();
    repeat (2) cyc(300, 300, 1);
    #3 reset = 1'b0;
    repeat (2) frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
